// File: rtl/cpu_pkg.sv
// Shared constants for the stack-based multicycle CPU.
// Word width, operand-stack geometry and A/B select encoding.
package cpu_pkg;

    localparam int DATA_W      = 8;
    localparam int STACK_DEPTH = 16;
    localparam int STACK_SP_W  = $clog2(STACK_DEPTH) + 1;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/stack_ram.sv
// Operand stack storage: one synchronous write port,
// one asynchronous read port, contents not reset.
module stack_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Hardware operand stack with A/B operand registers,
// command decode and sticky misuse flags.
module stack_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = cpu_pkg::STACK_DEPTH,
    parameter int SP_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic              A_or_B_stack_out_sel,
    input  logic              AWriteEnable,
    input  logic              BWriteEnable,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] top,
    output logic [SP_W-1:0]   sp,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic              cmd_err
);

    localparam int AW = $clog2(DEPTH);

    logic              do_push;
    logic              do_dec;
    logic              do_load;
    logic              set_ovf;
    logic              set_udf;
    logic              set_cmd;
    logic              load_a;
    logic              load_b;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr;
    logic [DATA_W-1:0] rdata;

    assign empty = (sp == '0);
    assign full  = (sp == SP_W'(DEPTH));
    assign waddr = AW'(sp);
    assign raddr = AW'(sp - SP_W'(1));
    assign top   = empty ? '0 : rdata;

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .we     (do_push),
        .waddr  (waddr),
        .wdata  (din),
        .raddr  (raddr),
        .rdata  (rdata)
    );

    // Guards on full/empty keep sp saturated and the array intact.
    always_comb begin
        do_push = 1'b0;
        do_dec  = 1'b0;
        do_load = 1'b0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        set_cmd = 1'b0;
        priority case (1'b1)
            push && (pop || tos): set_cmd = 1'b1;
            push: begin
                if (full) set_ovf = 1'b1;
                else      do_push = 1'b1;
            end
            pop || tos: begin
                if (empty) begin
                    set_udf = 1'b1;
                end else begin
                    do_load = 1'b1;
                    do_dec  = pop;
                end
            end
            default: ;
        endcase
    end

    assign load_a = do_load && (A_or_B_stack_out_sel == SEL_A) && AWriteEnable;
    assign load_b = do_load && (A_or_B_stack_out_sel == SEL_B) && BWriteEnable;

    always_ff @(posedge clk) begin
        if (reset) begin
            sp        <= '0;
            a_out     <= '0;
            b_out     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            if (do_push) sp <= sp + SP_W'(1);
            else if (do_dec) sp <= sp - SP_W'(1);
            if (load_a) a_out <= rdata;
            if (load_b) b_out <= rdata;
            if (set_ovf) overflow <= 1'b1;
            if (set_udf) underflow <= 1'b1;
            if (set_cmd) cmd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: push/pop/tos paths,
// saturation, misuse flags and reset priority.
module tb_stack_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic       tos;
    logic       sel;
    logic       awe;
    logic       bwe;
    logic [7:0] din;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic [7:0] top;
    logic [4:0] sp;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_unit dut (
        .clk                  (clk),
        .reset                (reset),
        .push                 (push),
        .pop                  (pop),
        .tos                  (tos),
        .A_or_B_stack_out_sel (sel),
        .AWriteEnable         (awe),
        .BWriteEnable         (bwe),
        .din                  (din),
        .a_out                (a_out),
        .b_out                (b_out),
        .top                  (top),
        .sp                   (sp),
        .empty                (empty),
        .full                 (full),
        .overflow             (overflow),
        .underflow            (underflow),
        .cmd_err              (cmd_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        tos   = 1'b0;
        sel   = 1'b0;
        awe   = 1'b0;
        bwe   = 1'b0;
        din   = 8'h00;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_sp", 32'(sp), 0);
        chk("rst_a", 32'(a_out), 0);
        chk("rst_b", 32'(b_out), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_top", 32'(top), 0);
        chk("rst_flags", {overflow, underflow, cmd_err}, 0);

        // three back-to-back pushes
        push = 1'b1;
        din = 8'h11; tick();
        din = 8'h22; tick();
        din = 8'h33; tick();
        idle();
        chk("push3_sp", 32'(sp), 3);
        chk("push3_top", 32'(top), 32'h33);
        chk("push3_flags", {overflow, underflow, cmd_err}, 0);

        // pop to A then pop to B on consecutive cycles
        pop = 1'b1; sel = 1'b0; awe = 1'b1; tick();
        sel = 1'b1; awe = 1'b0; bwe = 1'b1; tick();
        idle();
        chk("pop2_a", 32'(a_out), 32'h33);
        chk("pop2_b", 32'(b_out), 32'h22);
        chk("pop2_sp", 32'(sp), 1);
        chk("pop2_top", 32'(top), 32'h11);

        tos = 1'b1; sel = 1'b1; bwe = 1'b1; tick();
        idle();
        chk("tos_b", 32'(b_out), 32'h11);
        chk("tos_sp", 32'(sp), 1);

        // sel=A without AWE: word discarded even though BWE is high
        pop = 1'b1; sel = 1'b0; awe = 1'b0; bwe = 1'b1; tick();
        idle();
        chk("drop_sp", 32'(sp), 0);
        chk("drop_a", 32'(a_out), 32'h33);
        chk("drop_b", 32'(b_out), 32'h11);
        chk("drop_empty", 32'(empty), 1);
        chk("drop_top", 32'(top), 0);

        pop = 1'b1; awe = 1'b1; tick();
        idle();
        chk("udf_flag", 32'(underflow), 1);
        chk("udf_sp", 32'(sp), 0);
        chk("udf_a", 32'(a_out), 32'h33);
        chk("udf_b", 32'(b_out), 32'h11);
        chk("udf_ovf", 32'(overflow), 0);

        // fill: 16 pushes, then one more against full
        push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 8'(i);
            tick();
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_sp", 32'(sp), 16);
        chk("fill_top", 32'(top), 15);
        chk("fill_ovf0", 32'(overflow), 0);
        din = 8'd16;
        tick();
        idle();
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_sp", 32'(sp), 16);
        chk("ovf_top", 32'(top), 15);

        // pop and tos together: pop wins, loads A, no error
        pop = 1'b1; tos = 1'b1; sel = 1'b0; awe = 1'b1; tick();
        idle();
        chk("poptos_a", 32'(a_out), 15);
        chk("poptos_sp", 32'(sp), 15);
        chk("poptos_cmd", 32'(cmd_err), 0);

        // drain to sp=2 discarding words
        pop = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        idle();
        chk("drain_sp", 32'(sp), 2);
        chk("drain_top", 32'(top), 1);

        push = 1'b1; pop = 1'b1; din = 8'hAA; awe = 1'b1; tick();
        idle();
        chk("cmd_flag", 32'(cmd_err), 1);
        chk("cmd_sp", 32'(sp), 2);
        chk("cmd_top", 32'(top), 1);
        chk("cmd_a", 32'(a_out), 15);
        chk("cmd_b", 32'(b_out), 32'h11);

        push = 1'b1;
        din = 8'h40; tick();
        din = 8'h41; tick();
        din = 8'h42; tick();
        idle();
        chk("pre_rst_sp", 32'(sp), 5);
        chk("pre_rst_top", 32'(top), 32'h42);
        chk("pre_rst_flags", {overflow, underflow, cmd_err}, 3'b111);

        reset = 1'b1; push = 1'b1; din = 8'h77; tick();
        idle();
        chk("rst2_sp", 32'(sp), 0);
        chk("rst2_a", 32'(a_out), 0);
        chk("rst2_b", 32'(b_out), 0);
        chk("rst2_flags", {overflow, underflow, cmd_err}, 0);
        chk("rst2_top", 32'(top), 0);
        chk("rst2_empty", 32'(empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
